// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_DEPTH  = 64;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_e;

  typedef enum logic {
    P_CORE = 1'b0,
    P_DBG  = 1'b1
  } port_e;

  function automatic logic [31:0] byte_limit(input int unsigned depth);
    return 32'(depth * 4);
  endfunction

  localparam logic [31:0] BYTE_LIMIT = byte_limit(DMEM_DEPTH);

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant picker for the two arbiter ports.
// Build option DMEM_ARB_RR_EN selects round-robin instead of fixed port-0 priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic gnt_id_o,
  output logic gnt_vld_o
);

  assign gnt_vld_o = req0_i | req1_i;

`ifdef DMEM_ARB_RR_EN
  // On contention the port that was not granted last wins.
  always_comb begin
    if (req0_i && req1_i) begin
      gnt_id_o = ~last_grant_i;
    end else begin
      gnt_id_o = req0_i ? P_CORE : P_DBG;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign gnt_id_o          = req0_i ? P_CORE : P_DBG;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 64x32 data memory (async read, sync write).
// Build option DMEM_ARB_RR_EN enables round-robin arbitration in dmem_arb_pick.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned DEPTH  = DMEM_DEPTH,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = (DEPTH == DMEM_DEPTH) ? BYTE_LIMIT : byte_limit(DEPTH);

  state_e              state_q, state_d;
  logic                id_q, id_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic                ptr_q, ptr_d;

  logic                gnt_id, gnt_vld;
  logic                sel_we;
  logic [31:0]         sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_err;
  logic                ack_cycle;
  logic                active;

  // ptr_q holds the port favoured on the next contention; reset favours port 0.
  dmem_arb_pick u_pick (
    .req0_i       (req0),
    .req1_i       (req1),
    .last_grant_i (~ptr_q),
    .gnt_id_o     (gnt_id),
    .gnt_vld_o    (gnt_vld)
  );

  assign sel_we    = (gnt_id == P_DBG) ? we1    : we0;
  assign sel_addr  = (gnt_id == P_DBG) ? addr1  : addr0;
  assign sel_wdata = (gnt_id == P_DBG) ? wdata1 : wdata0;
  assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT);
  assign ack_cycle = ack0_q | ack1_q;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        // The cycle showing an ack is never re-arbitrated.
        if (gnt_vld && !ack_cycle) begin
          id_d    = gnt_id;
          we_d    = sel_we;
          err_d   = sel_err;
          idx_d   = sel_addr[IDX_W+1:2];
          wdata_d = sel_wdata;
          ptr_d   = ~gnt_id;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ack0_d  = (id_q == P_CORE);
        ack1_d  = (id_q == P_DBG);
        err0_d  = (id_q == P_CORE) && err_q;
        err1_d  = (id_q == P_DBG) && err_q;
        rdata_d = (!we_q && !err_q) ? mem_rdata : '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      ptr_q   <= ptr_d;
    end
  end

  // Memory strobes only in a clean ACCESS cycle, and never while reset is high.
  assign active    = (state_q == S_ACCESS) && !err_q && !reset;
  assign mem_read  = active && !we_q;
  assign mem_write = active && we_q;
  assign mem_addr  = active ? {{(32-IDX_W){1'b0}}, idx_q} : '0;
  assign mem_wdata = (active && we_q) ? wdata_q : '0;

  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign err0  = err0_q;
  assign err1  = err1_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, corner sequences, randomized traffic.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_init;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .DEPTH(64), .IDX_W(6)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: async read, sync write.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 + 32'(i) * 32'h0101;
    end else if (mem_write) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[5:0]];

  // Reference model: word array plus "last granted" port.
  logic [31:0] ref_mem [64];
  int          last_gnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              output bit err, output logic [31:0] rd);
    logic [5:0] idx;
    err = (addr[1:0] != 2'b00) || (addr >= 32'd256);
    rd  = '0;
    idx = addr[7:2];
    if (!err) begin
      if (we) ref_mem[idx] = wd;
      else    rd = ref_mem[idx];
    end
  endtask

  function automatic int model_winner();
    if (RR && last_gnt == 0) return 1;
    return 0;
  endfunction

  task automatic set_port(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic drop_port(input int p);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  // Invariants sampled every cycle outside reset.
  always @(negedge clk) begin
    if (!reset && !mem_init) begin
      chk1("ack_exclusive", ack0 & ack1, 1'b0);
      chk1("strobe_exclusive", mem_read & mem_write, 1'b0);
      if (!(ack0 | ack1)) chk("rdata_idle", rdata, 32'h0);
      if (mem_read | mem_write) chk1("mem_addr_range", mem_addr < 32'd64, 1'b1);
    end
  end

  // One transaction on one port; called right after a negedge with the DUT idle.
  task automatic do_single(input int p, input bit we, input logic [31:0] a, input logic [31:0] d,
                           input bit eerr, input logic [31:0] erd, input string tag);
    int          lat = 0;
    bit          got = 0;
    bit          strobe = 0, s_rd = 0, s_wr = 0;
    logic [31:0] s_addr = '0, s_wd = '0;
    logic        a_err, o_ack;
    set_port(p, we, a, d);
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_read | mem_write) begin
        strobe = 1; s_rd = mem_read; s_wr = mem_write; s_addr = mem_addr; s_wd = mem_wdata;
      end
      if ((p == 0) ? ack0 : ack1) got = 1;
    end
    a_err = (p == 0) ? err0 : err1;
    o_ack = (p == 0) ? ack1 : ack0;
    chk1({tag, "_ack"}, got, 1'b1);
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk1({tag, "_err"}, a_err, eerr);
    chk({tag, "_rdata"}, rdata, erd);
    chk1({tag, "_other_ack"}, o_ack, 1'b0);
    if (eerr) begin
      chk1({tag, "_no_strobe"}, strobe, 1'b0);
    end else begin
      chk1({tag, "_strobe"}, strobe, 1'b1);
      chk1({tag, "_mem_read"}, s_rd, !we);
      chk1({tag, "_mem_write"}, s_wr, we);
      chk({tag, "_mem_addr"}, s_addr, {2'b00, a[31:2]});
      if (we) chk({tag, "_mem_wdata"}, s_wd, d);
    end
    last_gnt = p;
    drop_port(p);
    @(negedge clk);
  endtask

  // Both ports request in the same cycle; winner acks at +2, loser at +5.
  task automatic do_pair(input bit wa, input logic [31:0] aa, input logic [31:0] da,
                         input bit wb, input logic [31:0] ab, input logic [31:0] db,
                         input string tag);
    int          w, at0, at1;
    bit          e0, e1;
    logic [31:0] r0, r1;
    w = model_winner();
    if (w == 0) begin
      model_access(wa, aa, da, e0, r0); model_access(wb, ab, db, e1, r1);
    end else begin
      model_access(wb, ab, db, e1, r1); model_access(wa, aa, da, e0, r0);
    end
    last_gnt = 1 - w;
    set_port(0, wa, aa, da);
    set_port(1, wb, ab, db);
    at0 = -1; at1 = -1;
    for (int c = 1; c <= 12 && (at0 < 0 || at1 < 0); c++) begin
      @(negedge clk);
      if (ack0) begin
        at0 = c; chk1({tag, "_err0"}, err0, e0); chk({tag, "_rdata0"}, rdata, r0); req0 = 1'b0;
      end
      if (ack1) begin
        at1 = c; chk1({tag, "_err1"}, err1, e1); chk({tag, "_rdata1"}, rdata, r1); req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk({tag, "_ack0_cycle"}, 32'(at0), (w == 0) ? 32'd2 : 32'd5);
    chk({tag, "_ack1_cycle"}, 32'(at1), (w == 1) ? 32'd2 : 32'd5);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    last_gnt = 1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
      1:       return 32'(256 + 4 * $urandom_range(0, 4000));
      2:       return 32'h0000_00FC;
      3:       return 32'(4 * $urandom_range(0, 63));
      default: return 32'(4 * $urandom_range(0, 7));
    endcase
  endfunction

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[13];

  initial begin
    bit          me, e;
    logic [31:0] mr, r;
    int          acks, cyc;

    vecs[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1, 1'b0, 32'h0000_0102, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1, 1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{0, 1'b1, 32'h0000_00FC, 32'h1234_5678, 1'b0, 32'h0};
    vecs[5]  = '{1, 1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'h1234_5678};
    vecs[6]  = '{0, 1'b1, 32'h0000_0013, 32'h5555_5555, 1'b1, 32'h0};
    vecs[7]  = '{1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[8]  = '{1, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[9]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'hA5A5_A5A5};
    vecs[10] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
    vecs[11] = '{1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'hA500_0101};
    vecs[12] = '{0, 1'b1, 32'h0000_00FF, 32'h7777_7777, 1'b1, 32'h0};

    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 + 32'(i) * 32'h0101;
    last_gnt = 1;

    // Reset state
    reset = 1'b1; mem_init = 1'b1;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    chk1("rst_ack0", ack0, 1'b0);
    chk1("rst_ack1", ack1, 1'b0);
    chk1("rst_err0", err0, 1'b0);
    chk1("rst_err1", err1, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, me, mr);
      do_single(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_err, vecs[i].exp_rd, $sformatf("vec%0d", i));
    end

    // Simultaneous reads, then mixed contention
    do_pair(1'b0, 32'h10, 32'h0, 1'b0, 32'hFC, 32'h0, "pair_rd");
    do_pair(1'b1, 32'h20, 32'h0BAD_CAFE, 1'b0, 32'h20, 32'h0, "pair_wr_rd");
    do_pair(1'b0, 32'h102, 32'h0, 1'b1, 32'h24, 32'h1111_2222, "pair_err");

    // Both ports hold req across five grants; port 0 drops after the fourth
    do_reset(2);
    set_port(0, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b0, 32'h14, 32'h0);
    acks = 0;
    cyc  = 0;
    while (acks < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack0 | ack1) begin
        int w;
        w = (acks < 4) ? model_winner() : 1;
        model_access(1'b0, (w == 0) ? 32'h10 : 32'h14, 32'h0, e, r);
        last_gnt = w;
        chk1($sformatf("hold_port%0d", acks), ack1, (w == 1));
        chk($sformatf("hold_rdata%0d", acks), rdata, r);
        chk($sformatf("hold_cycle%0d", acks), 32'(cyc), 32'(2 + 3 * acks));
        acks++;
        if (acks == 4) req0 = 1'b0;
        if (acks == 5) req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("hold_ack_count", 32'(acks), 32'd5);
    @(negedge clk);

    // Reset in the ACCESS cycle of a write
    set_port(0, 1'b1, 32'h20, 32'hCAFE_F00D);
    @(negedge clk);
    chk1("t6_mem_write_pre", mem_write, 1'b1);
    chk("t6_mem_addr_pre", mem_addr, 32'd8);
    reset = 1'b1;
    #1;
    chk1("t6_mem_write_rst", mem_write, 1'b0);
    chk1("t6_mem_read_rst", mem_read, 1'b0);
    @(negedge clk);
    chk1("t6_ack0", ack0, 1'b0);
    chk1("t6_ack1", ack1, 1'b0);
    chk1("t6_err0", err0, 1'b0);
    chk("t6_rdata", rdata, 32'h0);
    chk1("t6_mem_write", mem_write, 1'b0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    chk("t6_mem_wdata", mem_wdata, 32'h0);
    req0 = 1'b0;
    reset = 1'b0;
    last_gnt = 1;
    repeat (2) begin
      @(negedge clk);
      chk1("t6_no_late_ack", ack0, 1'b0);
    end
    model_access(1'b0, 32'h20, 32'h0, e, r);
    do_single(0, 1'b0, 32'h20, 32'h0, e, r, "t6_readback");

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_pair(1'($urandom_range(0, 1)), rand_addr(), $urandom(),
                1'($urandom_range(0, 1)), rand_addr(), $urandom(), $sformatf("rnd_pair%0d", n));
      end else begin
        int          p;
        bit          w;
        logic [31:0] a, d;
        p = int'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        a = rand_addr();
        d = $urandom();
        model_access(w, a, d, e, r);
        do_single(p, w, a, d, e, r, $sformatf("rnd%0d", n));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
